// File: rtl/comparador_serial_if.sv
// Handshake and operand/result bundle for the bit-serial magnitude comparator.
interface comparador_serial_if #(
    parameter int unsigned N = 3
);
    logic         start;
    logic         modo;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic         mayor;
    logic         igual;
    logic         menor;

    modport master (
        output start, modo, A, B,
        input  busy, done, mayor, igual, menor
    );

    modport slave (
        input  start, modo, A, B,
        output busy, done, mayor, igual, menor
    );
endinterface

// File: rtl/comparador_serial.sv
// Bit-serial N-bit unsigned magnitude comparator, one bit per clock.
// LSB-first scans all bits; MSB-first stops at the first differing bit.
module comparador_serial #(
    parameter int unsigned N = 3
) (
    input logic               clk,
    input logic               rst_n,
    comparador_serial_if.slave bus
);
    localparam int unsigned     IdxW    = $clog2(N);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;
    typedef enum logic [1:0] {FlagEq, FlagGt, FlagLt} flag_e;

    state_e          state_q, state_d;
    flag_e           flag_q, flag_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic            modo_q, modo_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [2:0]      res_q, res_d;  // {mayor, igual, menor}
    logic            bit_a, bit_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            flag_q  <= FlagEq;
            a_q     <= '0;
            b_q     <= '0;
            modo_q  <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            modo_q  <= modo_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        a_d     = a_q;
        b_d     = b_q;
        modo_d  = modo_q;
        idx_d   = idx_q;
        res_d   = res_q;
        bit_a   = a_q[idx_q];
        bit_b   = b_q[idx_q];

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    modo_d  = bus.modo;
                    flag_d  = FlagEq;
                    idx_d   = bus.modo ? IdxLast : '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bit_a != bit_b) begin
                    flag_d = bit_a ? FlagGt : FlagLt;
                end
                if (!modo_q) begin
                    // Later (more significant) differences overwrite earlier ones.
                    if (idx_q == IdxLast) state_d = StFin;
                    else                  idx_d   = idx_q + IdxW'(1);
                end else begin
                    if ((bit_a != bit_b) || (idx_q == '0)) state_d = StFin;
                    else                                  idx_d   = idx_q - IdxW'(1);
                end
                if (state_d == StFin) begin
                    res_d = {flag_d == FlagGt, flag_d == FlagEq, flag_d == FlagLt};
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StFin);
    assign bus.mayor = res_q[2];
    assign bus.igual = res_q[1];
    assign bus.menor = res_q[0];
endmodule

// File: tb/tb_comparador_serial.sv
// Directed and regression checks for comparador_serial at N=3 and N=8.
module tb_comparador_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comparador_serial_if #(.N(3)) bus3 ();
    comparador_serial_if #(.N(8)) bus8 ();

    comparador_serial #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    comparador_serial #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int total = 0;
    int bad   = 0;
    logic sel8 = 1'b0;
    logic o_busy, o_done;
    logic [2:0] o_res;

    always_comb begin
        o_busy = sel8 ? bus8.busy : bus3.busy;
        o_done = sel8 ? bus8.done : bus3.done;
        o_res  = sel8 ? {bus8.mayor, bus8.igual, bus8.menor}
                      : {bus3.mayor, bus3.igual, bus3.menor};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s8, input logic st, input logic m,
                         input logic [7:0] a, input logic [7:0] b);
        if (s8) begin
            bus8.start = st; bus8.modo = m; bus8.A = a; bus8.B = b;
        end else begin
            bus3.start = st; bus3.modo = m; bus3.A = a[2:0]; bus3.B = b[2:0];
        end
    endtask

    function automatic logic [2:0] rel(input logic [7:0] a, input logic [7:0] b);
        return {a > b, a == b, a < b};
    endfunction

    function automatic int lat_msb(input logic [7:0] a, input logic [7:0] b, input int n);
        int p = 0;
        for (int i = 0; i < n; i++) if (a[i] != b[i]) p = i;
        return n - p;
    endfunction

    // Starts a comparison, scrambles the operands right after the start edge,
    // then checks latency, result, FIN busy and the return to idle.
    task automatic run_cmp(input logic s8, input logic m, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] er, input int el,
                           input string tag);
        int lat = 0;
        logic got = 1'b0;
        sel8 = s8;
        drive(s8, 1'b1, m, a, b);
        @(posedge clk); #1;
        drive(s8, 1'b0, ~m, ~a, a ^ b);
        check({tag, "_busy_run"}, 32'(o_busy), 32'd1);
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_done) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(lat), 32'(el));
        check({tag, "_res"}, 32'(o_res), 32'(er));
        check({tag, "_busy_fin"}, 32'(o_busy), 32'd1);
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'({o_busy, o_done}), 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [7:0] a, b;

        drive(1'b0, 1'b1, 1'b0, 8'd5, 8'd3);
        drive(1'b1, 1'b1, 1'b0, 8'hF0, 8'h0F);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst3", 32'({bus3.busy, bus3.done, bus3.mayor, bus3.igual, bus3.menor}), 0);
            check("rst8", 32'({bus8.busy, bus8.done, bus8.mayor, bus8.igual, bus8.menor}), 0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmp(1'b0, 1'b0, 8'b101, 8'b011, 3'b100, 3, "lsb_101_011");
        run_cmp(1'b0, 1'b0, 8'b010, 8'b110, 3'b001, 3, "lsb_010_110");
        run_cmp(1'b0, 1'b1, 8'b100, 8'b011, 3'b100, 1, "msb_100_011");
        run_cmp(1'b0, 1'b1, 8'b101, 8'b100, 3'b100, 3, "msb_101_100");
        run_cmp(1'b0, 1'b1, 8'b110, 8'b110, 3'b010, 3, "msb_110_110");

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                run_cmp(1'b0, 1'b0, 8'(i), 8'(j), rel(8'(i), 8'(j)), 3, "sweep_lsb");
                run_cmp(1'b0, 1'b1, 8'(i), 8'(j), rel(8'(i), 8'(j)),
                        lat_msb(8'(i), 8'(j), 3), "sweep_msb");
            end
        end

        // Start held through RUN and FIN with other operands: only the first counts.
        sel8 = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 8'd5, 8'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd7);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_done) seen = 1'b1;
        end
        check("hs_lat", 32'(lat), 32'd3);
        check("hs_res", 32'(o_res), 32'b100);
        @(posedge clk); #1;
        check("hs_fin_ignored", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        check("hs_held_start", 32'(o_busy), 32'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_done) seen = 1'b1;
        end
        check("hs2_lat", 32'(lat), 32'd3);
        check("hs2_res", 32'(o_res), 32'b001);
        @(posedge clk); #1;
        check("hs2_idle", 32'(o_busy), 32'd0);

        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom);
            b = (k % 5 == 0) ? a : ((k % 3 == 0) ? a ^ 8'(1 << $urandom_range(7, 0))
                                                  : 8'($urandom));
            run_cmp(1'b1, 1'b0, a, b, rel(a, b), 8, "rand_lsb");
            run_cmp(1'b1, 1'b1, a, b, rel(a, b), lat_msb(a, b, 8), "rand_msb");
        end

        // Reset sampled at edge 4 of an 8-bit LSB-first run.
        run_cmp(1'b1, 1'b0, 8'h01, 8'h02, 3'b001, 8, "pre_rst");
        sel8 = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'hF0, 8'h0F);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= o_done;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        seen |= o_done;
        check("midrst_no_done", 32'(seen), 32'd0);
        check("midrst_outs", 32'({o_busy, o_done, o_res}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_still_idle", 32'({o_busy, o_done}), 32'd0);
        run_cmp(1'b1, 1'b0, 8'hF0, 8'h0F, 3'b100, 8, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
